// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port AXI4-lite read arbiter.
package arb_pkg;

   // Arbiter FSM: IDLE arbitrates, ADDR presents AR, DATA forwards R.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_t;

   localparam logic       ARB_PORT_IBUS = 1'b0;
   localparam logic       ARB_PORT_DBUS = 1'b1;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin winner select.
// A lone requester always wins; on a tie the port named by prio_i wins.
module rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       prio_i,
   output logic       any_o,
   output logic       win_o
);

   // Winner index and "someone is asking" flag.
   always_comb begin
      any_o = |valid_i;
      win_o = (&valid_i) ? prio_i : valid_i[1];
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4-lite read port between ibus (port 0) and dbus (port 1).
// Handshake rule on every channel: a transfer happens in the cycle where
// valid and ready are both high; valid, once raised by this block, is held
// with its payload stable until the matching ready is seen.
// One transaction is in flight at a time; arbitration only happens in IDLE.
module axi_rd_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // port 0 (ibus)
   input  logic [ADDR_WIDTH-1:0] s0_araddr_i,
   input  logic [2:0]            s0_arprot_i,
   input  logic                  s0_arvalid_i,
   output logic                  s0_arready_o,
   output logic [DATA_WIDTH-1:0] s0_rdata_o,
   output logic [1:0]            s0_rresp_o,
   output logic                  s0_rvalid_o,
   input  logic                  s0_rready_i,
   // port 1 (dbus)
   input  logic [ADDR_WIDTH-1:0] s1_araddr_i,
   input  logic [2:0]            s1_arprot_i,
   input  logic                  s1_arvalid_i,
   output logic                  s1_arready_o,
   output logic [DATA_WIDTH-1:0] s1_rdata_o,
   output logic [1:0]            s1_rresp_o,
   output logic                  s1_rvalid_o,
   input  logic                  s1_rready_i,
   // memory side
   output logic [ADDR_WIDTH-1:0] m_araddr_o,
   output logic [2:0]            m_arprot_o,
   output logic                  m_arvalid_o,
   input  logic                  m_arready_i,
   input  logic [DATA_WIDTH-1:0] m_rdata_i,
   input  logic [1:0]            m_rresp_i,
   input  logic                  m_rvalid_i,
   output logic                  m_rready_o,
   // debug: current FSM state
   output arb_state_t            dbg_state_o
);

   arb_state_t            r_state;
   arb_state_t            w_next_state;
   logic                  r_grant;
   logic                  r_prio;
   logic [ADDR_WIDTH-1:0] r_addr_q;
   logic [2:0]            r_prot_q;

   logic                  w_any;
   logic                  w_win;
   logic                  w_accept;
   logic                  w_r_hs;

   rr_arb2 u_rr_arb2 (
      .valid_i ({s1_arvalid_i, s0_arvalid_i}),
      .prio_i  (r_prio),
      .any_o   (w_any),
      .win_o   (w_win)
   );

   // Next state and all handshake/forwarding outputs, decoded from state.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_r_hs       = 1'b0;
      s0_arready_o = 1'b0;
      s1_arready_o = 1'b0;
      s0_rdata_o   = '0;
      s0_rresp_o   = 2'b00;
      s0_rvalid_o  = 1'b0;
      s1_rdata_o   = '0;
      s1_rresp_o   = 2'b00;
      s1_rvalid_o  = 1'b0;
      m_araddr_o   = '0;
      m_arprot_o   = 3'b000;
      m_arvalid_o  = 1'b0;
      m_rready_o   = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            s0_arready_o = w_any && (w_win == ARB_PORT_IBUS);
            s1_arready_o = w_any && (w_win == ARB_PORT_DBUS);
            w_accept     = w_any;
            if (w_any) w_next_state = ARB_ADDR;
         end
         ARB_ADDR: begin
            m_arvalid_o = 1'b1;
            m_araddr_o  = r_addr_q;
            m_arprot_o  = r_prot_q;
            if (m_arready_i) w_next_state = ARB_DATA;
         end
         ARB_DATA: begin
            if (r_grant == ARB_PORT_DBUS) begin
               m_rready_o  = s1_rready_i;
               s1_rvalid_o = m_rvalid_i;
               s1_rdata_o  = m_rdata_i;
               s1_rresp_o  = m_rresp_i;
            end else begin
               m_rready_o  = s0_rready_i;
               s0_rvalid_o = m_rvalid_i;
               s0_rdata_o  = m_rdata_i;
               s0_rresp_o  = m_rresp_i;
            end
            w_r_hs = m_rvalid_i && m_rready_o;
            if (w_r_hs) w_next_state = ARB_IDLE;
         end
         default: w_next_state = ARB_IDLE;
      endcase
   end

   // State, grant, priority and captured request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ARB_IDLE;
         r_grant  <= ARB_PORT_IBUS;
         r_prio   <= ARB_PORT_DBUS;
         r_addr_q <= '0;
         r_prot_q <= 3'b000;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_grant  <= w_win;
            r_addr_q <= w_win ? s1_araddr_i : s0_araddr_i;
            r_prot_q <= w_win ? s1_arprot_i : s0_arprot_i;
         end
         // loser of the finished transaction is favoured next time
         if (w_r_hs) r_prio <= ~r_grant;
      end
   end

   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed testbench for axi_rd_arbiter.
module tb_axi_rd_arbiter;
   import arb_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] s0_araddr_i, s1_araddr_i, m_araddr_o;
   logic [2:0]  s0_arprot_i, s1_arprot_i, m_arprot_o;
   logic        s0_arvalid_i, s1_arvalid_i, s0_arready_o, s1_arready_o;
   logic [31:0] s0_rdata_o, s1_rdata_o, m_rdata_i;
   logic [1:0]  s0_rresp_o, s1_rresp_o, m_rresp_i;
   logic        s0_rvalid_o, s1_rvalid_o, s0_rready_i, s1_rready_i;
   logic        m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;
   arb_state_t  dbg_state_o;

   int n_cmp = 0;
   int n_err = 0;

   axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s0_araddr_i(s0_araddr_i), .s0_arprot_i(s0_arprot_i), .s0_arvalid_i(s0_arvalid_i),
      .s0_arready_o(s0_arready_o), .s0_rdata_o(s0_rdata_o), .s0_rresp_o(s0_rresp_o),
      .s0_rvalid_o(s0_rvalid_o), .s0_rready_i(s0_rready_i),
      .s1_araddr_i(s1_araddr_i), .s1_arprot_i(s1_arprot_i), .s1_arvalid_i(s1_arvalid_i),
      .s1_arready_o(s1_arready_o), .s1_rdata_o(s1_rdata_o), .s1_rresp_o(s1_rresp_o),
      .s1_rvalid_o(s1_rvalid_o), .s1_rready_i(s1_rready_i),
      .m_araddr_o(m_araddr_o), .m_arprot_o(m_arprot_o), .m_arvalid_o(m_arvalid_o),
      .m_arready_i(m_arready_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
      .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
      .dbg_state_o(dbg_state_o)
   );

   // clock
   always #5 clk_i = ~clk_i;

   // hard time limit
   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "time limit");
   end

   // advance to 2ns after the next rising edge (drive point)
   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      s0_araddr_i = '0; s0_arprot_i = '0; s0_arvalid_i = 1'b0; s0_rready_i = 1'b0;
      s1_araddr_i = '0; s1_arprot_i = '0; s1_arvalid_i = 1'b0; s1_rready_i = 1'b0;
      m_arready_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0; m_rvalid_i = 1'b0;
      tick(); tick();
      #1;
      n_cmp++; if (dbg_state_o !== ARB_IDLE) begin n_err++; $display("FAIL rst_state got=%0d want=%0d", dbg_state_o, ARB_IDLE); end
      n_cmp++; if (m_arvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_m_arvalid got=%b want=0", m_arvalid_o); end
      n_cmp++; if (m_araddr_o !== 32'h0) begin n_err++; $display("FAIL rst_m_araddr got=%h want=0", m_araddr_o); end
      n_cmp++; if ({s0_arready_o, s1_arready_o, s0_rvalid_o, s1_rvalid_o, m_rready_o} !== 5'b0) begin
         n_err++; $display("FAIL rst_handshakes got=%b want=00000", {s0_arready_o, s1_arready_o, s0_rvalid_o, s1_rvalid_o, m_rready_o}); end
      n_cmp++; if ({s0_rdata_o, s1_rdata_o} !== 64'h0) begin n_err++; $display("FAIL rst_rdata got=%h want=0", {s0_rdata_o, s1_rdata_o}); end
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_single_ibus();
      s0_arvalid_i = 1'b1; s0_araddr_i = 32'h0000_0010; s0_arprot_i = 3'b010;
      m_rvalid_i = 1'b1; // stray rvalid in IDLE must be ignored
      #1;
      n_cmp++; if (s0_arready_o !== 1'b1) begin n_err++; $display("FAIL single_s0_arready got=%b want=1", s0_arready_o); end
      n_cmp++; if (s1_arready_o !== 1'b0) begin n_err++; $display("FAIL single_s1_arready got=%b want=0", s1_arready_o); end
      n_cmp++; if ({m_rready_o, s0_rvalid_o} !== 2'b00) begin n_err++; $display("FAIL idle_rvalid_ignored got=%b want=00", {m_rready_o, s0_rvalid_o}); end
      tick();
      s0_arvalid_i = 1'b0; m_rvalid_i = 1'b0; m_arready_i = 1'b1;
      #1;
      n_cmp++; if (m_arvalid_o !== 1'b1) begin n_err++; $display("FAIL single_m_arvalid got=%b want=1", m_arvalid_o); end
      n_cmp++; if (m_araddr_o !== 32'h10) begin n_err++; $display("FAIL single_m_araddr got=%h want=10", m_araddr_o); end
      n_cmp++; if (m_arprot_o !== 3'b010) begin n_err++; $display("FAIL single_m_arprot got=%b want=010", m_arprot_o); end
      tick();
      m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hDEAD_BEEF; m_rresp_i = AXI_RESP_OKAY; s0_rready_i = 1'b1;
      #1;
      n_cmp++; if (s0_rvalid_o !== 1'b1) begin n_err++; $display("FAIL single_s0_rvalid got=%b want=1", s0_rvalid_o); end
      n_cmp++; if (s0_rdata_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_s0_rdata got=%h want=deadbeef", s0_rdata_o); end
      n_cmp++; if (s0_rresp_o !== AXI_RESP_OKAY) begin n_err++; $display("FAIL single_s0_rresp got=%b want=00", s0_rresp_o); end
      n_cmp++; if ({s1_rvalid_o, s1_rdata_o} !== 33'h0) begin n_err++; $display("FAIL single_s1_quiet got=%h want=0", {s1_rvalid_o, s1_rdata_o}); end
      n_cmp++; if (m_rready_o !== 1'b1) begin n_err++; $display("FAIL single_m_rready got=%b want=1", m_rready_o); end
      tick();
      m_rvalid_i = 1'b0; s0_rready_i = 1'b0;
      #1;
      n_cmp++; if (dbg_state_o !== ARB_IDLE) begin n_err++; $display("FAIL single_back_idle got=%0d want=%0d", dbg_state_o, ARB_IDLE); end
   endtask

   task automatic test_back_to_back();
      logic        exp_port;
      logic [31:0] exp_addr;
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      s0_arvalid_i = 1'b1; s0_araddr_i = 32'h100; s0_arprot_i = 3'b000;
      s1_arvalid_i = 1'b1; s1_araddr_i = 32'h200; s1_arprot_i = 3'b001;
      s0_rready_i = 1'b1; s1_rready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_port = (i % 2 == 0) ? 1'b1 : 1'b0;
         exp_addr = exp_port ? 32'h200 : 32'h100;
         #1;
         n_cmp++; if ({s1_arready_o, s0_arready_o} !== {exp_port, ~exp_port}) begin
            n_err++; $display("FAIL b2b_grant%0d got=%b want=%b", i, {s1_arready_o, s0_arready_o}, {exp_port, ~exp_port}); end
         tick();
         m_arready_i = 1'b1;
         #1;
         n_cmp++; if (m_araddr_o !== exp_addr) begin n_err++; $display("FAIL b2b_addr%0d got=%h want=%h", i, m_araddr_o, exp_addr); end
         tick();
         m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h1000 + i;
         #1;
         n_cmp++; if ({s1_rvalid_o, s0_rvalid_o} !== {exp_port, ~exp_port}) begin
            n_err++; $display("FAIL b2b_rvalid%0d got=%b want=%b", i, {s1_rvalid_o, s0_rvalid_o}, {exp_port, ~exp_port}); end
         n_cmp++; if ((exp_port ? s1_rdata_o : s0_rdata_o) !== 32'h1000 + i) begin
            n_err++; $display("FAIL b2b_rdata%0d got=%h want=%h", i, exp_port ? s1_rdata_o : s0_rdata_o, 32'h1000 + i); end
         tick();
         m_rvalid_i = 1'b0;
      end
      s0_arvalid_i = 1'b0; s1_arvalid_i = 1'b0; s0_rready_i = 1'b0; s1_rready_i = 1'b0;
      tick();
   endtask

   task automatic test_addr_backpressure();
      s0_arvalid_i = 1'b1; s0_araddr_i = 32'h40;
      tick();
      s0_arvalid_i = 1'b0; s1_arvalid_i = 1'b1; s1_araddr_i = 32'h80; m_arready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_cmp++; if ({m_arvalid_o, m_araddr_o} !== {1'b1, 32'h40}) begin
            n_err++; $display("FAIL arbp_hold%0d got=%b/%h want=1/40", k, m_arvalid_o, m_araddr_o); end
         n_cmp++; if ({s0_arready_o, s1_arready_o} !== 2'b00) begin
            n_err++; $display("FAIL arbp_arready%0d got=%b want=00", k, {s0_arready_o, s1_arready_o}); end
         tick();
      end
      m_arready_i = 1'b1;
      tick();
      m_arready_i = 1'b0; m_rvalid_i = 1'b1; s0_rready_i = 1'b1; m_rdata_i = 32'h4444;
      tick();
      m_rvalid_i = 1'b0; s0_rready_i = 1'b0;
      #1;
      n_cmp++; if (s1_arready_o !== 1'b1) begin n_err++; $display("FAIL arbp_pending_s1 got=%b want=1", s1_arready_o); end
      tick();
      s1_arvalid_i = 1'b0; m_arready_i = 1'b1;
      tick();
      m_arready_i = 1'b0; m_rvalid_i = 1'b1; s1_rready_i = 1'b1;
      tick();
      m_rvalid_i = 1'b0; s1_rready_i = 1'b0;
   endtask

   task automatic test_data_backpressure();
      s1_arvalid_i = 1'b1; s1_araddr_i = 32'h300;
      #1;
      n_cmp++; if (s1_arready_o !== 1'b1) begin n_err++; $display("FAIL dbp_s1_accept got=%b want=1", s1_arready_o); end
      tick();
      s1_arvalid_i = 1'b0; s0_arvalid_i = 1'b1; s0_araddr_i = 32'h400; m_arready_i = 1'b1;
      tick();
      m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h3333; s1_rready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if ({m_rready_o, s1_rvalid_o} !== 2'b01) begin
            n_err++; $display("FAIL dbp_stall%0d got=%b want=01", k, {m_rready_o, s1_rvalid_o}); end
         n_cmp++; if (dbg_state_o !== ARB_DATA) begin n_err++; $display("FAIL dbp_state%0d got=%0d want=%0d", k, dbg_state_o, ARB_DATA); end
         n_cmp++; if (s0_arready_o !== 1'b0) begin n_err++; $display("FAIL dbp_s0_wait%0d got=%b want=0", k, s0_arready_o); end
         tick();
      end
      s1_rready_i = 1'b1;
      #1;
      n_cmp++; if (m_rready_o !== 1'b1) begin n_err++; $display("FAIL dbp_release got=%b want=1", m_rready_o); end
      tick();
      m_rvalid_i = 1'b0; s1_rready_i = 1'b0;
      #1;
      n_cmp++; if (s0_arready_o !== 1'b1) begin n_err++; $display("FAIL dbp_s0_accept got=%b want=1", s0_arready_o); end
      tick();
      s0_arvalid_i = 1'b0; m_arready_i = 1'b1;
      #1;
      n_cmp++; if (m_araddr_o !== 32'h400) begin n_err++; $display("FAIL dbp_s0_addr got=%h want=400", m_araddr_o); end
      tick();
      m_arready_i = 1'b0; m_rvalid_i = 1'b1; s0_rready_i = 1'b1;
      tick();
      m_rvalid_i = 1'b0; s0_rready_i = 1'b0;
   endtask

   task automatic test_error_resp();
      s0_arvalid_i = 1'b1; s0_araddr_i = 32'h20;
      tick();
      s0_arvalid_i = 1'b0; m_arready_i = 1'b1;
      tick();
      m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0; m_rresp_i = 2'b10; s0_rready_i = 1'b1;
      #1;
      n_cmp++; if ({s0_rvalid_o, s0_rresp_o} !== 3'b110) begin n_err++; $display("FAIL err_slverr got=%b want=110", {s0_rvalid_o, s0_rresp_o}); end
      tick();
      m_rvalid_i = 1'b0; m_rresp_i = AXI_RESP_OKAY; s0_rready_i = 1'b0;
      s0_arvalid_i = 1'b1; s0_araddr_i = 32'h24;
      #1;
      n_cmp++; if (s0_arready_o !== 1'b1) begin n_err++; $display("FAIL err_next_accept got=%b want=1", s0_arready_o); end
      tick();
      s0_arvalid_i = 1'b0; m_arready_i = 1'b1;
      #1;
      n_cmp++; if (m_araddr_o !== 32'h24) begin n_err++; $display("FAIL err_next_addr got=%h want=24", m_araddr_o); end
      tick();
      m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h1234_5678; s0_rready_i = 1'b1;
      #1;
      n_cmp++; if ({s0_rresp_o, s0_rdata_o} !== {AXI_RESP_OKAY, 32'h1234_5678}) begin
         n_err++; $display("FAIL err_next_data got=%b/%h want=00/12345678", s0_rresp_o, s0_rdata_o); end
      tick();
      m_rvalid_i = 1'b0; s0_rready_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      // finish an s1 read so priority points at s0 before the reset
      s1_arvalid_i = 1'b1; s1_araddr_i = 32'h500;
      tick();
      s1_arvalid_i = 1'b0; m_arready_i = 1'b1;
      tick();
      m_arready_i = 1'b0; m_rvalid_i = 1'b1; s1_rready_i = 1'b1;
      tick();
      m_rvalid_i = 1'b0; s1_rready_i = 1'b0;
      s0_arvalid_i = 1'b1; s0_araddr_i = 32'h600;
      tick();
      s0_arvalid_i = 1'b0; m_arready_i = 1'b1;
      tick();
      m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hAAAA_5555; s0_rready_i = 1'b0;
      #1;
      n_cmp++; if (dbg_state_o !== ARB_DATA) begin n_err++; $display("FAIL rmid_in_data got=%0d want=%0d", dbg_state_o, ARB_DATA); end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0; m_rvalid_i = 1'b0;
      #1;
      n_cmp++; if (dbg_state_o !== ARB_IDLE) begin n_err++; $display("FAIL rmid_state got=%0d want=%0d", dbg_state_o, ARB_IDLE); end
      n_cmp++; if ({m_arvalid_o, m_rready_o, s0_rvalid_o, s0_rdata_o} !== 35'h0) begin
         n_err++; $display("FAIL rmid_outputs got=%h want=0", {m_arvalid_o, m_rready_o, s0_rvalid_o, s0_rdata_o}); end
      s0_arvalid_i = 1'b1; s0_araddr_i = 32'h100;
      s1_arvalid_i = 1'b1; s1_araddr_i = 32'h200;
      #1;
      n_cmp++; if ({s1_arready_o, s0_arready_o} !== 2'b10) begin
         n_err++; $display("FAIL rmid_dbus_first got=%b want=10", {s1_arready_o, s0_arready_o}); end
      tick();
      s0_arvalid_i = 1'b0; s1_arvalid_i = 1'b0;
      #1;
      n_cmp++; if (m_araddr_o !== 32'h200) begin n_err++; $display("FAIL rmid_addr got=%h want=200", m_araddr_o); end
   endtask

   // test sequence and report
   initial begin
      test_reset();
      test_single_ibus();
      test_back_to_back();
      test_addr_backpressure();
      test_data_backpressure();
      test_error_resp();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI4-lite read port to the unified memory between the hxd32 instruction-fetch read requester (port 0, ibus) and the load read requester (port 1, dbus).
- Round-robin arbitration with a single outstanding transaction.
- The address is registered toward memory; read data and response are forwarded combinationally back to the granted requester.
- Sits between the core's ibus/dbus read interfaces and the memory/interconnect slave.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, read data width on all ports.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- s0_araddr_i  in  ADDR_WIDTH  port 0 (ibus) read address.
- s0_arprot_i  in  3  port 0 protection.
- s0_arvalid_i  in  1  port 0 address valid.
- s0_arready_o  out  1  port 0 address accepted.
- s0_rdata_o  out  DATA_WIDTH  port 0 read data.
- s0_rresp_o  out  2  port 0 response.
- s0_rvalid_o  out  1  port 0 data valid.
- s0_rready_i  in  1  port 0 data ready.
- s1_araddr_i, s1_arprot_i, s1_arvalid_i, s1_arready_o, s1_rdata_o, s1_rresp_o, s1_rvalid_o, s1_rready_i: same as port 0, for port 1 (dbus).
- m_araddr_o  out  ADDR_WIDTH  memory read address.
- m_arprot_o  out  3  memory protection.
- m_arvalid_o  out  1  memory address valid.
- m_arready_i  in  1  memory address ready.
- m_rdata_i  in  DATA_WIDTH  memory read data.
- m_rresp_i  in  2  memory response.
- m_rvalid_i  in  1  memory data valid.
- m_rready_o  out  1  memory data ready.

Behaviour:
- State machine, encoded as arb_state_t:
  - IDLE -> ADDR when any sX_arvalid_i is high.
  - ADDR -> DATA on m_arvalid_o && m_arready_i.
  - DATA -> IDLE on m_rvalid_i && m_rready_o.
- Registers: state, grant (1 bit), prio (1 bit), addr_q, prot_q.
- Reset: state=IDLE, grant=0, prio=1 (dbus favoured first), addr_q=0, prot_q=0. All outputs 0; rdata/rresp outputs read as 0 while not forwarding.
- Arbitration happens in IDLE only:
  - Winner is the sole requester; on a tie, the winner is port prio.
  - sX_arready_o = (state==IDLE) && winner==X. It is combinational, high in the same cycle as the request, and at most one port is high at a time.
  - On acceptance: grant<=winner; addr_q/prot_q <= winner's address/prot.
- ADDR: m_arvalid_o=1, m_araddr_o=addr_q, m_arprot_o=prot_q. These are held stable until m_arready_i; no retraction.
- DATA forwarding:
  - s[grant]_rvalid_o = m_rvalid_i; s[grant]_rdata_o/rresp_o = m_rdata_i/m_rresp_i.
  - m_rready_o = s[grant]_rready_i.
  - The non-granted port sees rvalid=0.
  - On r handshake: prio <= ~grant (loser of last grant gets priority), state <= IDLE.
- Latency: request accepted cycle N; m_arvalid_o high cycle N+1; zero-wait memory returns data at N+2; next acceptance earliest at N+3.
- Boundary conditions:
  - m_rvalid_i in IDLE/ADDR: ignored, m_rready_o=0.
  - SLVERR/DECERR (rresp 2'b10/2'b11) forwarded unchanged; no retry.
  - Requester holding rready low stalls DATA indefinitely; the other port waits.
  - A non-granted arvalid stays pending with arready=0 until next IDLE.
  - Reset asserted in any state: next cycle IDLE with reset values. The in-flight transaction is abandoned; memory is reset in the same domain.
  - Back-to-back requests from both ports strictly alternate. No port waits more than one transaction.

Decomposition:
- Shared package (arb_pkg): typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_ADDR, ARB_DATA}; constants ARB_PORT_IBUS=1'b0, ARB_PORT_DBUS=1'b1; AXI_RESP_OKAY=2'b00.
- One sub-module: rr_arb2 (combinational 2-way round-robin winner select from valid pair + prio; registers stay in the parent).

Test Plan:
- Single ibus read: after reset, s0_arvalid=1, addr 0x0000_0010 -> s0_arready=1 same cycle; m_arvalid=1 next cycle with m_araddr=0x10; memory returns 0xDEAD_BEEF/OKAY -> s0_rvalid=1, s0_rdata=0xDEAD_BEEF; s1_rvalid=0.
- Simultaneous requests from reset: s0 addr 0x100, s1 addr 0x200, both held -> grant order s1, s0, s1, s0 (prio alternates); m_araddr sequence 0x200,0x100,0x200,0x100.
- Address backpressure: m_arready held 0 for 5 cycles -> m_arvalid/m_araddr stable all 5 cycles; s0/s1 arready stay 0.
- Data backpressure: s1_rready=0 for 3 cycles while m_rvalid=1 -> m_rready=0, state stays DATA; pending s0 request not accepted until cycle after s1 handshake.
- Error response: memory returns rresp=2'b10, rdata=0x0 -> granted port sees rresp=2'b10; next transaction proceeds normally.
- Reset mid-transaction: rst_i=1 while in DATA -> next cycle all outputs 0, prio=1; subsequent dual request grants s1 first.
